// File: rtl/sel_ctrl.sv
// Tournament chooser controller: picks between two component predictions using a
// saturating chooser table, and trains it as branches resolve. Optional stats via SEL_CTRL_STAT_EN.
module sel_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      pred_valid,
    output logic                      pred_ready,
    input  logic [ADDR_W-1:0]         pred_idx,
    input  logic                      p0_taken,
    input  logic                      p1_taken,
    output logic                      final_valid,
    output logic                      final_taken,
    output logic                      final_sel,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic                      res_taken,
    output logic [$clog2(DEPTH):0]    inflight,
    output logic [ADDR_W-1:0]         tab_addr,
    input  logic [CNT_W-1:0]          tab_rd_data,
    output logic                      tab_up_en,
    output logic [CNT_W-1:0]          tab_up_data
`ifdef SEL_CTRL_STAT_EN
    ,
    output logic [15:0]               stat_res,
    output logic [15:0]               stat_mis
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [ADDR_W-1:0] q_idx [DEPTH];
    logic              q_p0  [DEPTH];
    logic              q_p1  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              do_res;
    logic              do_pred;
    logic              sel;
    logic              pick;
    logic [CNT_W:0]    inc_wide;
    logic [CNT_W:0]    dec_wide;

    assign inflight = count;

    // Arbitration for the single table port plus the saturating counter update.
    always_comb begin
        res_ready   = !flush && (count != '0);
        do_res      = res_valid && res_ready;
        pred_ready  = !flush && (count != FULL_CNT) && !do_res;
        do_pred     = pred_valid && pred_ready;
        sel         = tab_rd_data[CNT_W-1];
        pick        = sel ? p1_taken : p0_taken;
        inc_wide    = {1'b0, tab_rd_data} + (CNT_W+1)'(1);
        dec_wide    = {1'b0, tab_rd_data} - (CNT_W+1)'(1);
        tab_addr    = pred_idx;
        tab_up_en   = 1'b0;
        tab_up_data = tab_rd_data;
        if (do_res) begin
            tab_addr = q_idx[rd_ptr];
            if (q_p0[rd_ptr] != q_p1[rd_ptr]) begin
                tab_up_en = 1'b1;
                if (q_p1[rd_ptr] == res_taken) begin
                    tab_up_data = (inc_wide > CNT_MAX) ? {CNT_W{1'b1}} : inc_wide[CNT_W-1:0];
                end else begin
                    tab_up_data = dec_wide[CNT_W] ? '0 : dec_wide[CNT_W-1:0];
                end
            end
        end
    end

    // Queue payload needs no reset: only entries below the occupancy count are ever read.
    always_ff @(posedge clk) begin
        if (do_pred) begin
            q_idx[wr_ptr] <= pred_idx;
            q_p0[wr_ptr]  <= p0_taken;
            q_p1[wr_ptr]  <= p1_taken;
        end
    end

    // Pointers, occupancy and the registered final prediction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            final_valid <= 1'b0;
            final_taken <= 1'b0;
            final_sel   <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            final_valid <= 1'b0;
        end else begin
            final_valid <= do_pred;
            if (do_pred) begin
                final_taken <= pick;
                final_sel   <= sel;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                count       <= count + (PTR_W+1)'(1);
            end else if (do_res) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                count       <= count - (PTR_W+1)'(1);
            end
        end
    end

`ifdef SEL_CTRL_STAT_EN
    logic q_tk [DEPTH];

    always_ff @(posedge clk) begin
        if (do_pred) begin
            q_tk[wr_ptr] <= pick;
        end
    end

    // Saturating resolution and misprediction counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_res <= '0;
            stat_mis <= '0;
        end else if (flush) begin
            stat_res <= '0;
            stat_mis <= '0;
        end else if (do_res) begin
            if (stat_res != 16'hFFFF) begin
                stat_res <= stat_res + 16'd1;
            end
            if ((q_tk[rd_ptr] != res_taken) && (stat_mis != 16'hFFFF)) begin
                stat_mis <= stat_mis + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sel_ctrl.sv
// Directed testbench for sel_ctrl: reset, lookup/update pairs, full queue, flush and mid-update reset.
module tb_sel_ctrl;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       pred_valid;
    logic       pred_ready;
    logic [9:0] pred_idx;
    logic       p0_taken;
    logic       p1_taken;
    logic       final_valid;
    logic       final_taken;
    logic       final_sel;
    logic       res_valid;
    logic       res_ready;
    logic       res_taken;
    logic [2:0] inflight;
    logic [9:0] tab_addr;
    logic [1:0] tab_rd_data;
    logic       tab_up_en;
    logic [1:0] tab_up_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0] idx;
        logic       p0;
        logic       p1;
        logic [1:0] rd_look;
        logic       exp_taken;
        logic       exp_sel;
        logic       res_tk;
        logic [1:0] rd_res;
        logic       exp_en;
        logic [1:0] exp_data;
    } upd_row_t;

    sel_ctrl #(.ADDR_W(10), .CNT_W(2), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .pred_idx    (pred_idx),
        .p0_taken    (p0_taken),
        .p1_taken    (p1_taken),
        .final_valid (final_valid),
        .final_taken (final_taken),
        .final_sel   (final_sel),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_taken   (res_taken),
        .inflight    (inflight),
        .tab_addr    (tab_addr),
        .tab_rd_data (tab_rd_data),
        .tab_up_en   (tab_up_en),
        .tab_up_data (tab_up_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (final_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_final_valid got=%0h exp=0", final_valid); end
        total++; if (final_taken !== 1'b0) begin bad++; $display("[TB] FAIL rst_final_taken got=%0h exp=0", final_taken); end
        total++; if (final_sel !== 1'b0) begin bad++; $display("[TB] FAIL rst_final_sel got=%0h exp=0", final_sel); end
        total++; if (inflight !== 3'd0) begin bad++; $display("[TB] FAIL rst_inflight got=%0h exp=0", inflight); end
        total++; if (pred_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_pred_ready got=%0h exp=1", pred_ready); end
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_res_ready got=%0h exp=0", res_ready); end
        total++; if (tab_up_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_tab_up_en got=%0h exp=0", tab_up_en); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        total++; if (inflight !== 3'd0) begin bad++; $display("[TB] FAIL rel_inflight got=%0h exp=0", inflight); end
    endtask

    // Each row: one lookup, then its resolution, with hand-computed counter update.
    task automatic test_update();
        upd_row_t rows [6];
        rows[0] = {10'd5,  1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'b11};
        rows[1] = {10'd7,  1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 2'b11};
        rows[2] = {10'd9,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00};
        rows[3] = {10'd3,  1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00};
        rows[4] = {10'd12, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b10};
        rows[5] = {10'd20, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00};
        for (int i = 0; i < 6; i++) begin
            pred_valid  = 1'b1;
            pred_idx    = rows[i].idx;
            p0_taken    = rows[i].p0;
            p1_taken    = rows[i].p1;
            tab_rd_data = rows[i].rd_look;
            #1;
            total++; if (tab_addr !== rows[i].idx) begin bad++; $display("[TB] FAIL upd%0d_look_addr got=%0h exp=%0h", i, tab_addr, rows[i].idx); end
            tick();
            pred_valid = 1'b0;
            pred_idx   = 10'h3ff;
            total++; if (final_valid !== 1'b1) begin bad++; $display("[TB] FAIL upd%0d_final_valid got=%0h exp=1", i, final_valid); end
            total++; if (final_taken !== rows[i].exp_taken) begin bad++; $display("[TB] FAIL upd%0d_final_taken got=%0h exp=%0h", i, final_taken, rows[i].exp_taken); end
            total++; if (final_sel !== rows[i].exp_sel) begin bad++; $display("[TB] FAIL upd%0d_final_sel got=%0h exp=%0h", i, final_sel, rows[i].exp_sel); end
            total++; if (inflight !== 3'd1) begin bad++; $display("[TB] FAIL upd%0d_inflight_push got=%0h exp=1", i, inflight); end
            res_valid   = 1'b1;
            res_taken   = rows[i].res_tk;
            tab_rd_data = rows[i].rd_res;
            #1;
            total++; if (res_ready !== 1'b1) begin bad++; $display("[TB] FAIL upd%0d_res_ready got=%0h exp=1", i, res_ready); end
            total++; if (tab_addr !== rows[i].idx) begin bad++; $display("[TB] FAIL upd%0d_res_addr got=%0h exp=%0h", i, tab_addr, rows[i].idx); end
            total++; if (tab_up_en !== rows[i].exp_en) begin bad++; $display("[TB] FAIL upd%0d_up_en got=%0h exp=%0h", i, tab_up_en, rows[i].exp_en); end
            if (rows[i].exp_en) begin
                total++; if (tab_up_data !== rows[i].exp_data) begin bad++; $display("[TB] FAIL upd%0d_up_data got=%0h exp=%0h", i, tab_up_data, rows[i].exp_data); end
            end
            tick();
            res_valid = 1'b0;
            total++; if (inflight !== 3'd0) begin bad++; $display("[TB] FAIL upd%0d_inflight_pop got=%0h exp=0", i, inflight); end
            total++; if (final_valid !== 1'b0) begin bad++; $display("[TB] FAIL upd%0d_final_pulse got=%0h exp=0", i, final_valid); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            pred_valid  = 1'b1;
            pred_idx    = 10'(i);
            p0_taken    = 1'b0;
            p1_taken    = 1'b1;
            tab_rd_data = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            total++; if (pred_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_pred_ready got=%0h exp=1", i, pred_ready); end
            tick();
            total++; if (final_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_final_valid got=%0h exp=1", i, final_valid); end
            total++; if (final_taken !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin bad++; $display("[TB] FAIL b2b%0d_final_taken got=%0h exp=%0h", i, final_taken, (i % 2 == 0)); end
            total++; if (inflight !== 3'(i + 1)) begin bad++; $display("[TB] FAIL b2b%0d_inflight got=%0h exp=%0h", i, inflight, i + 1); end
        end
        total++; if (pred_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_pred_ready got=%0h exp=0", pred_ready); end
        res_valid = 1'b1;
        res_taken = 1'b1;
        #1;
        total++; if (res_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_res_ready got=%0h exp=1", res_ready); end
        total++; if (pred_ready !== 1'b0) begin bad++; $display("[TB] FAIL both_pred_ready got=%0h exp=0", pred_ready); end
        tick();
        res_valid  = 1'b0;
        pred_valid = 1'b0;
        #1;
        total++; if (inflight !== 3'd3) begin bad++; $display("[TB] FAIL both_inflight got=%0h exp=3", inflight); end
        total++; if (final_valid !== 1'b0) begin bad++; $display("[TB] FAIL both_final_valid got=%0h exp=0", final_valid); end
        total++; if (pred_ready !== 1'b1) begin bad++; $display("[TB] FAIL both_pred_ready_after got=%0h exp=1", pred_ready); end
    endtask

    task automatic test_flush();
        res_valid = 1'b1;
        tick();
        res_valid   = 1'b0;
        pred_valid  = 1'b1;
        pred_idx    = 10'd40;
        p0_taken    = 1'b0;
        p1_taken    = 1'b1;
        tab_rd_data = 2'b10;
        tick();
        pred_valid = 1'b0;
        total++; if (inflight !== 3'd3) begin bad++; $display("[TB] FAIL fl_pre_inflight got=%0h exp=3", inflight); end
        total++; if (final_valid !== 1'b1) begin bad++; $display("[TB] FAIL fl_pre_final_valid got=%0h exp=1", final_valid); end
        flush      = 1'b1;
        res_valid  = 1'b1;
        pred_valid = 1'b1;
        #1;
        total++; if (tab_up_en !== 1'b0) begin bad++; $display("[TB] FAIL fl_tab_up_en got=%0h exp=0", tab_up_en); end
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL fl_res_ready got=%0h exp=0", res_ready); end
        total++; if (pred_ready !== 1'b0) begin bad++; $display("[TB] FAIL fl_pred_ready got=%0h exp=0", pred_ready); end
        tick();
        flush      = 1'b0;
        res_valid  = 1'b0;
        pred_valid = 1'b0;
        #1;
        total++; if (inflight !== 3'd0) begin bad++; $display("[TB] FAIL fl_inflight got=%0h exp=0", inflight); end
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL fl_res_ready_after got=%0h exp=0", res_ready); end
        total++; if (final_valid !== 1'b0) begin bad++; $display("[TB] FAIL fl_final_valid got=%0h exp=0", final_valid); end
        total++; if (pred_ready !== 1'b1) begin bad++; $display("[TB] FAIL fl_pred_ready_after got=%0h exp=1", pred_ready); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            pred_valid  = 1'b1;
            pred_idx    = 10'(30 + i);
            p0_taken    = 1'b1;
            p1_taken    = 1'b0;
            tab_rd_data = 2'b00;
            tick();
        end
        pred_valid = 1'b0;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        tab_rd_data = 2'b01;
        #1;
        total++; if (tab_up_en !== 1'b1) begin bad++; $display("[TB] FAIL rm_pre_up_en got=%0h exp=1", tab_up_en); end
        total++; if (final_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_pre_final_valid got=%0h exp=1", final_valid); end
        reset_n = 1'b0;
        #1;
        total++; if (tab_up_en !== 1'b0) begin bad++; $display("[TB] FAIL rm_up_en got=%0h exp=0", tab_up_en); end
        total++; if (inflight !== 3'd0) begin bad++; $display("[TB] FAIL rm_inflight got=%0h exp=0", inflight); end
        total++; if (final_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_final_valid got=%0h exp=0", final_valid); end
        total++; if (res_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_res_ready got=%0h exp=0", res_ready); end
        res_valid = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
        pred_valid  = 1'b1;
        pred_idx    = 10'd12;
        p0_taken    = 1'b1;
        p1_taken    = 1'b0;
        tab_rd_data = 2'b10;
        #1;
        total++; if (tab_addr !== 10'd12) begin bad++; $display("[TB] FAIL rm_look_addr got=%0h exp=c", tab_addr); end
        tick();
        pred_valid = 1'b0;
        total++; if (final_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_final_valid_after got=%0h exp=1", final_valid); end
        total++; if (final_taken !== 1'b0) begin bad++; $display("[TB] FAIL rm_final_taken got=%0h exp=0", final_taken); end
        total++; if (final_sel !== 1'b1) begin bad++; $display("[TB] FAIL rm_final_sel got=%0h exp=1", final_sel); end
        total++; if (inflight !== 3'd1) begin bad++; $display("[TB] FAIL rm_inflight_after got=%0h exp=1", inflight); end
    endtask

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        pred_valid  = 1'b0;
        pred_idx    = '0;
        p0_taken    = 1'b0;
        p1_taken    = 1'b0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        tab_rd_data = '0;
        test_reset();
        test_update();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
